// File: rtl/exec_sequencer_pkg.sv
// Shared definitions for the execution sequencer: FSM state encodings and the
// default memory-wait timeout.
package exec_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IF  = 3'd0,
        ST_ID  = 3'd1,
        ST_EX  = 3'd2,
        ST_MEM = 3'd3,
        ST_WB  = 3'd4,
        ST_ERR = 3'd5
    } state_t;

    localparam int TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/exec_sequencer_wait_timer.sv
// Wait counter for pending memory requests; expired is decoded from the
// registered count so a same-cycle ready can still take priority upstream.
module wait_timer #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            // saturate at the limit so a long stall can never wrap back to zero
            count <= count + W'(1);
        end
    end

    assign expired = (count >= limit);

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle instruction sequencer: IF/ID/EX/MEM/WB with a bus-error trap
// when instruction or data memory fails to answer within TIMEOUT cycles.
module exec_sequencer
    import exec_sequencer_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        halt,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        RegWrite,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        Jal,
    output logic        imem_req,
    output logic        ir_we,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        reg_we,
    output logic        pc_we,
    output logic        bus_err,
    output logic [2:0]  state,
    output logic [31:0] instr_count
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1) + 1;

    state_t state_q, state_d;
    logic   f_reg_write, f_mem_read, f_mem_write, f_jal;
    logic   wait_clear, wait_enable, wait_expired;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IF;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            f_reg_write <= 1'b0;
            f_mem_read  <= 1'b0;
            f_mem_write <= 1'b0;
            f_jal       <= 1'b0;
        end else if (state_q == ST_EX) begin
            f_reg_write <= RegWrite;
            f_mem_read  <= MemRead;
            f_mem_write <= MemWrite;
            f_jal       <= Jal;
        end
    end

    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        reg_we   = 1'b0;
        pc_we    = 1'b0;
        case (state_q)
            ST_IF: begin
                if (!halt) begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_we   = 1'b1;
                        state_d = ST_ID;
                    end else if (wait_expired) begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_ID: state_d = ST_EX;
            ST_EX: begin
                if (MemRead || MemWrite) begin
                    state_d = ST_MEM;
                end else if (RegWrite || Jal) begin
                    state_d = ST_WB;
                end else begin
                    pc_we   = 1'b1;
                    state_d = ST_IF;
                end
            end
            ST_MEM: begin
                // a combined read+write is issued as a write but still writes back
                dmem_req = 1'b1;
                dmem_we  = f_mem_write;
                if (dmem_ready) begin
                    if (f_mem_read) begin
                        state_d = ST_WB;
                    end else begin
                        pc_we   = 1'b1;
                        state_d = ST_IF;
                    end
                end else if (wait_expired) begin
                    state_d = ST_ERR;
                end
            end
            ST_WB: begin
                reg_we  = f_reg_write || f_jal || f_mem_read;
                pc_we   = 1'b1;
                state_d = ST_IF;
            end
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_IF;
        endcase
        // the fetch request is the only input-driven output; keep it quiet in reset
        if (reset) begin
            imem_req = 1'b0;
            ir_we    = 1'b0;
        end
    end

    assign wait_clear  = (state_d != state_q) && (state_d == ST_IF || state_d == ST_MEM);
    assign wait_enable = (state_q == ST_IF  && !halt && !imem_ready) ||
                         (state_q == ST_MEM && !dmem_ready);

    wait_timer #(.W(WAIT_W)) u_wait_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (wait_clear),
        .enable  (wait_enable),
        .limit   (WAIT_W'(TIMEOUT)),
        .expired (wait_expired)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instr_count <= 32'd0;
        end else if (pc_we) begin
            instr_count <= instr_count + 32'd1;
        end
    end

    assign bus_err = (state_q == ST_ERR);
    assign state   = state_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Scoreboard bench for exec_sequencer: per-cycle expected state/strobe vectors
// are queued with their stimulus, then replayed and compared cycle by cycle.
module tb_exec_sequencer;
    import exec_sequencer_pkg::*;

    logic        clock = 1'b0;
    logic        reset, halt, imem_ready, dmem_ready;
    logic        RegWrite, MemRead, MemWrite, Jal;
    logic        imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, bus_err;
    logic [2:0]  state;
    logic [31:0] instr_count;
    logic [6:0]  outs;

    typedef struct {
        logic [3:0] fl;   // {RegWrite, MemRead, MemWrite, Jal}
        logic       imr;
        logic       dmr;
        logic [2:0] st;
        logic [6:0] o;    // {imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, bus_err}
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_count;

    localparam logic [3:0] F_NOP   = 4'b0000;
    localparam logic [3:0] F_ALU   = 4'b1000;
    localparam logic [3:0] F_LOAD  = 4'b1100;
    localparam logic [3:0] F_STORE = 4'b0010;
    localparam logic [3:0] F_BOTH  = 4'b1110;
    localparam logic [3:0] F_JAL   = 4'b0001;

    exec_sequencer #(.TIMEOUT(TIMEOUT_DEFAULT)) dut (
        .clock(clock), .reset(reset), .halt(halt),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .Jal(Jal),
        .imem_req(imem_req), .ir_we(ir_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .reg_we(reg_we), .pc_we(pc_we), .bus_err(bus_err),
        .state(state), .instr_count(instr_count)
    );

    assign outs = {imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, bus_err};

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    function automatic void push(input logic [3:0] fl, input logic imr, input logic dmr,
                                 input logic [2:0] st, input logic [6:0] o);
        exp_t e;
        e.fl = fl; e.imr = imr; e.dmr = dmr; e.st = st; e.o = o;
        sb.push_back(e);
    endfunction

    // Expected cycle-by-cycle trace of one instruction, derived from the
    // stage sequence: iw fetch stalls, then IF,ID,EX,[MEM x (dw+1)],[WB].
    function automatic void build_instr(input logic [3:0] fl, input int iw, input int dw);
        logic mem, mr, mw, wb;
        mr  = fl[2];
        mw  = fl[1];
        mem = mr | mw;
        wb  = mem ? mr : (fl[3] | fl[0]);
        for (int i = 0; i < iw; i++) push(fl, 1'b0, 1'b0, 3'd0, 7'b1000000);
        push(fl, 1'b1, 1'b0, 3'd0, 7'b1100000);
        push(fl, 1'b0, 1'b0, 3'd1, 7'b0000000);
        push(fl, 1'b0, 1'b0, 3'd2, (!mem && !wb) ? 7'b0000010 : 7'b0000000);
        if (mem) begin
            for (int k = 0; k < dw; k++) push(fl, 1'b0, 1'b0, 3'd3, {3'b001, mw, 3'b000});
            push(fl, 1'b0, 1'b1, 3'd3, {3'b001, mw, 1'b0, !mr, 1'b0});
        end
        if (wb) push(fl, 1'b0, 1'b0, 3'd4, 7'b0000110);
        exp_count = exp_count + 32'd1;
    endfunction

    // Entered and left at posedge+1; each queued entry is one clock cycle.
    task automatic run_sb(input string name);
        exp_t e;
        int   cyc = 0;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            {RegWrite, MemRead, MemWrite, Jal} = e.fl;
            imem_ready = e.imr;
            dmem_ready = e.dmr;
            @(negedge clock);
            n_checks++;
            if (state !== e.st || outs !== e.o) begin
                n_fail++;
                $display("FAIL %s cycle %0d: state=%0d outs=%b, expected state=%0d outs=%b",
                         name, cyc, state, outs, e.st, e.o);
            end
            @(posedge clock); #1;
            cyc++;
        end
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
    endtask

    task automatic release_reset();
        halt = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0;
        {RegWrite, MemRead, MemWrite, Jal} = 4'b0000;
        @(negedge clock) reset = 1'b0;
        @(posedge clock); #1;
        exp_count = 32'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1; halt = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1;
        {RegWrite, MemRead, MemWrite, Jal} = 4'b1111;
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if (state !== 3'd0) begin
            n_fail++; $display("FAIL reset_state: got %0d, want 0", state);
        end
        n_checks++;
        if (outs !== 7'b0) begin
            n_fail++; $display("FAIL reset_outputs: got %b, want 0000000", outs);
        end
        n_checks++;
        if (instr_count !== 32'd0) begin
            n_fail++; $display("FAIL reset_count: got %0d, want 0", instr_count);
        end
        release_reset();
    endtask

    task automatic run_one(input string name, input logic [3:0] fl, input int iw, input int dw);
        halt = 1'b0;
        build_instr(fl, iw, dw);
        run_sb(name);
        halt = 1'b1;
        n_checks++;
        if (instr_count !== exp_count) begin
            n_fail++;
            $display("FAIL %s_count: got %0d, want %0d", name, instr_count, exp_count);
        end
    endtask

    task automatic test_alu();          run_one("alu", F_ALU, 0, 0);          endtask
    task automatic test_nop();          run_one("nop", F_NOP, 0, 0);          endtask
    task automatic test_jal();          run_one("jal", F_JAL, 0, 0);          endtask
    task automatic test_store();        run_one("store", F_STORE, 0, 0);      endtask
    task automatic test_load_delayed(); run_one("load_delay3", F_LOAD, 0, 3); endtask
    task automatic test_load_store();   run_one("read_write", F_BOTH, 0, 1);  endtask
    task automatic test_imem_wait();    run_one("imem_wait", F_ALU, 2, 0);    endtask
    task automatic test_timeout_race(); run_one("ready_at_timeout", F_STORE, 0, TIMEOUT_DEFAULT); endtask

    task automatic test_back_to_back();
        halt = 1'b0;
        build_instr(F_ALU, 0, 0);
        build_instr(F_STORE, 0, 2);
        build_instr(F_LOAD, 1, 0);
        build_instr(F_NOP, 0, 0);
        run_sb("back_to_back");
        halt = 1'b1;
        n_checks++;
        if (instr_count !== exp_count) begin
            n_fail++;
            $display("FAIL back_to_back_count: got %0d, want %0d", instr_count, exp_count);
        end
    endtask

    task automatic test_halt();
        halt = 1'b1; imem_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            n_checks++;
            if (state !== 3'd0 || imem_req !== 1'b0 || ir_we !== 1'b0) begin
                n_fail++;
                $display("FAIL halt cycle %0d: state=%0d imem_req=%b ir_we=%b, want 0/0/0",
                         i, state, imem_req, ir_we);
            end
            @(posedge clock); #1;
        end
        run_one("after_halt", F_ALU, 0, 0);
    endtask

    task automatic test_timeout();
        halt = 1'b0;
        push(F_STORE, 1'b1, 1'b0, 3'd0, 7'b1100000);
        push(F_STORE, 1'b0, 1'b0, 3'd1, 7'b0000000);
        push(F_STORE, 1'b0, 1'b0, 3'd2, 7'b0000000);
        for (int k = 0; k <= TIMEOUT_DEFAULT; k++) push(F_STORE, 1'b0, 1'b0, 3'd3, 7'b0011000);
        // ERR must ignore late readies and halt state
        for (int k = 0; k < 4; k++) push(F_STORE, 1'b1, 1'b1, 3'd5, 7'b0000001);
        run_sb("timeout");
        n_checks++;
        if (instr_count !== exp_count) begin
            n_fail++;
            $display("FAIL timeout_no_retire: got %0d, want %0d", instr_count, exp_count);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (state !== 3'd0 || outs !== 7'b0) begin
            n_fail++;
            $display("FAIL err_reset: state=%0d outs=%b, want 0 and 0000000", state, outs);
        end
        release_reset();
    endtask

    task automatic test_reset_mid_mem();
        halt = 1'b0;
        push(F_LOAD, 1'b1, 1'b0, 3'd0, 7'b1100000);
        push(F_LOAD, 1'b0, 1'b0, 3'd1, 7'b0000000);
        push(F_LOAD, 1'b0, 1'b0, 3'd2, 7'b0000000);
        push(F_LOAD, 1'b0, 1'b0, 3'd3, 7'b0010000);
        push(F_LOAD, 1'b0, 1'b0, 3'd3, 7'b0010000);
        run_sb("pre_abort");
        reset = 1'b1;
        #1;
        n_checks++;
        if (state !== 3'd0 || outs !== 7'b0 || instr_count !== 32'd0) begin
            n_fail++;
            $display("FAIL mem_abort: state=%0d outs=%b count=%0d, want 0/0000000/0",
                     state, outs, instr_count);
        end
        release_reset();
        run_one("fetch_after_abort", F_ALU, 0, 0);
    endtask

    task automatic test_wrap();
        halt = 1'b1;
        force dut.instr_count = 32'hFFFF_FFFF;
        @(negedge clock);
        release dut.instr_count;
        @(posedge clock); #1;
        n_checks++;
        if (instr_count !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL preload: got %h, want ffffffff", instr_count);
        end
        exp_count = 32'hFFFF_FFFF;
        run_one("wrap", F_ALU, 0, 0);
        n_checks++;
        if (instr_count !== 32'd0) begin
            n_fail++;
            $display("FAIL wrap_zero: got %h, want 00000000", instr_count);
        end
    endtask

    initial begin
        exp_count = 32'd0;
        test_reset();
        test_alu();
        test_nop();
        test_jal();
        test_store();
        test_load_delayed();
        test_load_store();
        test_imem_wait();
        test_back_to_back();
        test_halt();
        test_timeout_race();
        test_timeout();
        test_reset_mid_mem();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
